// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - two-requester round-robin SPI master sequencer (one byte per command)
module spi_master_ctrl #(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_W     = $clog2(NUM_SLAVES)
) (
    input  logic                    sclk,
    input  logic                    rst,
    input  logic [1:0]              req,
    input  logic [2*ADDR_W-1:0]     addr,
    input  logic [1:0]              wr,
    input  logic [1:0]              rd,
    input  logic [15:0]             tx_data,
    output logic [1:0]              gnt,
    output logic [1:0]              done,
    output logic [7:0]              rx_data,
    output logic                    busy,
    output logic [NUM_SLAVES-1:0]   select,
    output logic                    write_en,
    output logic                    read_en,
    output logic                    MOSI,
    input  logic                    MISO
);

    typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, TAIL} state_t;

    state_t                state_q, state_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic                  ptr_q, ptr_d;
    logic                  cur_q, cur_d;
    logic                  wr_q, wr_d;
    logic                  rd_q, rd_d;
    logic [7:0]            tx_q, tx_d;
    logic [6:0]            rx_shift_q, rx_shift_d;
    logic [1:0]            gnt_q, gnt_d;
    logic [1:0]            done_q, done_d;
    logic [7:0]            rx_data_q, rx_data_d;
    logic                  busy_q, busy_d;
    logic [NUM_SLAVES-1:0] select_q, select_d;
    logic                  write_en_q, write_en_d;
    logic                  read_en_q, read_en_d;
    logic                  mosi_q, mosi_d;
    logic                  pick;
    logic [ADDR_W-1:0]     sel_addr;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        ptr_d      = ptr_q;
        cur_d      = cur_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        tx_d       = tx_q;
        rx_shift_d = rx_shift_q;
        gnt_d      = 2'b00;
        done_d     = 2'b00;
        rx_data_d  = rx_data_q;
        busy_d     = busy_q;
        select_d   = select_q;
        write_en_d = write_en_q;
        read_en_d  = read_en_q;
        mosi_d     = mosi_q;
        // Contention goes to the pointer; a lone request wins outright.
        pick       = (req == 2'b11) ? ptr_q : req[1];
        sel_addr   = addr[ADDR_W*pick +: ADDR_W];

        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    cur_d    = pick;
                    ptr_d    = ~pick;
                    wr_d     = wr[pick];
                    rd_d     = rd[pick];
                    tx_d     = tx_data[8*pick +: 8];
                    gnt_d    = 2'b01 << pick;
                    busy_d   = 1'b1;
                    select_d = {{(NUM_SLAVES-1){1'b0}}, 1'b1} << sel_addr;
                    state_d  = CLEAR;
                end
            end
            CLEAR: begin
                bit_cnt_d  = 3'd0;
                write_en_d = wr_q;
                read_en_d  = rd_q;
                mosi_d     = tx_q[7];
                state_d    = SHIFT;
            end
            SHIFT: begin
                // MISO lags the slave's shift edge by one cycle, so capture trails bit_cnt.
                if (rd_q && (bit_cnt_q != 3'd0))
                    rx_shift_d[bit_cnt_q - 3'd1] = MISO;
                if (bit_cnt_q == 3'd7) begin
                    write_en_d = 1'b0;
                    read_en_d  = 1'b0;
                    mosi_d     = 1'b0;
                    bit_cnt_d  = 3'd0;
                    state_d    = TAIL;
                end else begin
                    mosi_d    = tx_q[3'd6 - bit_cnt_q];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            TAIL: begin
                select_d  = '0;
                rx_data_d = rd_q ? {MISO, rx_shift_q} : 8'h00;
                done_d    = 2'b01 << cur_q;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 3'd0;
            ptr_q      <= 1'b0;
            cur_q      <= 1'b0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            tx_q       <= 8'h00;
            rx_shift_q <= 7'h00;
            gnt_q      <= 2'b00;
            done_q     <= 2'b00;
            rx_data_q  <= 8'h00;
            busy_q     <= 1'b0;
            select_q   <= '0;
            write_en_q <= 1'b0;
            read_en_q  <= 1'b0;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            ptr_q      <= ptr_d;
            cur_q      <= cur_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            tx_q       <= tx_d;
            rx_shift_q <= rx_shift_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            rx_data_q  <= rx_data_d;
            busy_q     <= busy_d;
            select_q   <= select_d;
            write_en_q <= write_en_d;
            read_en_q  <= read_en_d;
            mosi_q     <= mosi_d;
        end
    end

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign rx_data  = rx_data_q;
    assign busy     = busy_q;
    assign select   = select_q;
    assign write_en = write_en_q;
    assign read_en  = read_en_q;
    assign MOSI     = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb/tb_spi_master_ctrl.sv - directed self-checking bench for spi_master_ctrl with a behavioural slave
module tb_spi_master_ctrl;

    logic        sclk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [3:0]  addr;
    logic [1:0]  wr;
    logic [1:0]  rd;
    logic [15:0] tx_data;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic [7:0]  rx_data;
    logic        busy;
    logic [3:0]  select;
    logic        write_en;
    logic        read_en;
    logic        MOSI;
    logic        MISO;

    int checks = 0;
    int errors = 0;

    logic [7:0] s_data_in;
    logic [7:0] s_data_out;
    logic [2:0] s_rcnt;
    logic       wr_seen, rd_seen;

    always #5 sclk = ~sclk;

    spi_master_ctrl #(.NUM_SLAVES(4)) dut (
        .sclk(sclk), .rst(rst), .req(req), .addr(addr), .wr(wr), .rd(rd),
        .tx_data(tx_data), .gnt(gnt), .done(done), .rx_data(rx_data),
        .busy(busy), .select(select), .write_en(write_en), .read_en(read_en),
        .MOSI(MOSI), .MISO(MISO)
    );

    // Slave: counters clear whenever both enables are low; MOSI shifts in MSB first,
    // data_in shifts out LSB first one edge after read_en is seen.
    always @(posedge sclk) begin
        if (!write_en && !read_en) begin
            s_rcnt <= 3'd0;
        end else begin
            if (write_en) s_data_out <= {s_data_out[6:0], MOSI};
            if (read_en) begin
                MISO   <= s_data_in[s_rcnt];
                s_rcnt <= s_rcnt + 3'd1;
            end
        end
        if (write_en) wr_seen <= 1'b1;
        if (read_en)  rd_seen <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic run_txn(input int i, input logic [1:0] a, input logic w, input logic r,
                           input logic [7:0] tx, input logic [7:0] din);
        req = 2'b00; req[i] = 1'b1;
        addr[2*i +: 2]   = a;
        wr[i]            = w;
        rd[i]            = r;
        tx_data[8*i +: 8] = tx;
        s_data_in = din;
        wr_seen = 1'b0;
        rd_seen = 1'b0;
        tick();
        chk("gnt_E0", {30'd0, gnt}, 32'd1 << i);
        chk("busy_E0", {31'd0, busy}, 32'd1);
        chk("sel_E0", {28'd0, select}, 32'd1 << a);
        req = 2'b00;
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk("sel_hold", {28'd0, select}, 32'd1 << a);
            chk("no_done", {30'd0, done}, 32'd0);
            chk("gnt_low", {30'd0, gnt}, 32'd0);
            if (k == 9 && w) chk("slave_data_out", {24'd0, s_data_out}, {24'd0, tx});
        end
        tick();
        chk("done_E10", {30'd0, done}, 32'd1 << i);
        chk("rx_data", {24'd0, rx_data}, r ? {24'd0, din} : 32'd0);
        chk("busy_E10", {31'd0, busy}, 32'd0);
        chk("sel_E10", {28'd0, select}, 32'd0);
        chk("wr_seen", {31'd0, wr_seen}, {31'd0, w});
        chk("rd_seen", {31'd0, rd_seen}, {31'd0, r});
        tick();
        chk("done_pulse", {30'd0, done}, 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1; req = 2'b00; addr = 4'h0; wr = 2'b00; rd = 2'b00; tx_data = 16'h0;
        s_data_in = 8'h00; s_data_out = 8'h00; s_rcnt = 3'd0; MISO = 1'b0;
        wr_seen = 1'b0; rd_seen = 1'b0;
        #12;
        chk("reset_outs", {gnt, done, rx_data, busy, select, write_en, read_en, MOSI}, 32'd0);
        @(negedge sclk);
        rst = 1'b0;
        tick();

        run_txn(0, 2'd2, 1'b1, 1'b0, 8'hA5, 8'h00);
        run_txn(1, 2'd1, 1'b0, 1'b1, 8'h00, 8'h3C);
        run_txn(0, 2'd3, 1'b1, 1'b1, 8'h81, 8'h7E);
        run_txn(1, 2'd0, 1'b0, 1'b0, 8'hFF, 8'hC3);

        // Reset in the middle of SHIFT.
        req = 2'b01; addr = 4'h2; wr = 2'b11; rd = 2'b11; tx_data = 16'hFFFF;
        tick();
        req = 2'b00;
        tick(); tick(); tick();
        chk("mid_shift_busy", {31'd0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort_outs", {gnt, done, rx_data, busy, select, write_en, read_en, MOSI}, 32'd0);
        tick();
        rst = 1'b0;
        chk("abort_no_done", {30'd0, done}, 32'd0);
        run_txn(0, 2'd1, 1'b1, 1'b0, 8'h5A, 8'h00);

        // Arbitration: both requesters held; pointer was reset to requester 0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        addr = 4'h0; wr = 2'b00; rd = 2'b00;
        req = 2'b11;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            do begin
                tick();
                n++;
            end while (gnt == 2'b00 && n <= 20);
            chk("arb_timeout", {31'd0, (n <= 20)}, 32'd1);
            chk("arb_gnt", {30'd0, gnt}, (g % 2) ? 32'd2 : 32'd1);
            if (g > 0) chk("arb_spacing", n, 32'd11);
        end
        req = 2'b00;
        n = 0;
        do begin
            tick();
            n++;
        end while (done == 2'b00 && n <= 20);
        chk("arb_last_done", {30'd0, done}, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
